inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter A, default 12, instruction address width (matches instruction ROM address width).
REQ-002 SHALL have parameter W, default 9, instruction word width (matches instruction ROM data width).
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  program launch/restart request, sampled on Clk.
REQ-006 SHALL have port Stall  input  1  hold current PC this cycle.
REQ-007 SHALL have port BranchAbs  input  1  load PC with Target.
REQ-008 SHALL have port BranchRel  input  1  add sign-extended Target to PC.
REQ-009 SHALL have port Target  input  A  absolute address or two's-complement offset.
REQ-010 SHALL have port InstIn  input  W  instruction word returned combinationally by instruction ROM for InstAddress.
REQ-011 SHALL have port InstAddress  output  A  PC driven to instruction ROM, taken directly from the PC register.
REQ-012 SHALL have port InstValid  output  1  high while InstIn is an executable instruction.
REQ-013 SHALL have port Done  output  1  registered program-complete flag.
REQ-014 SHALL have port CycleCnt  output  16  run-cycle count (present only per REQ-031).

Function
REQ-015 SHALL implement states IDLE, RUN, HALT; InstValid = 1 only in RUN, combinationally from state.
REQ-016 SHALL, in any state, on Start=1 at an edge: PC<=0, Done<=0, state<=RUN (Start is highest priority after Reset).
REQ-017 SHALL, in IDLE without Start, hold PC=0 and Done=0.
REQ-018 SHALL, in RUN, detect halt when InstIn == all ones (W bits): next edge state<=HALT, Done<=1, PC unchanged.
REQ-019 SHALL, in RUN without halt, apply priority Stall > BranchAbs > BranchRel > increment at each edge.
REQ-020 SHALL on Stall hold PC; branch inputs ignored that cycle.
REQ-021 SHALL on BranchAbs set PC<=Target; BranchAbs wins if both branch inputs are high.
REQ-022 SHALL on BranchRel set PC<=PC+signext(Target), modulo 2^A.
REQ-023 SHALL otherwise set PC<=PC+1, wrapping 2^A-1 -> 0.
REQ-024 SHALL, in HALT, hold PC and Done=1 and ignore Stall/branch inputs; exit only via Start or Reset.
REQ-025 SHALL have zero-cycle fetch latency: instruction at PC is valid on InstIn in the same cycle InstAddress=PC.
REQ-026 SHALL treat halt detection as higher priority than Stall and branches in the same cycle.

Reset
REQ-027 SHALL on Reset=1 immediately (asynchronously) force state=IDLE, PC=0, Done=0, InstValid=0, CycleCnt=0.
REQ-028 SHALL on Reset asserted mid-RUN or mid-HALT abandon execution; no partial PC update survives.
REQ-029 SHALL remain in IDLE after Reset release until Start is sampled high.
REQ-030 SHALL ignore Start while Reset is high.

Configuration
REQ-031 SHALL include the CycleCnt port and counter only when macro FETCH_CYCLE_CNT_EN is defined; without it the port and logic are absent and all other behaviour is identical.
REQ-032 SHALL, with FETCH_CYCLE_CNT_EN, increment CycleCnt once per edge spent in RUN (including stalled and halting cycles), saturate at 16'hFFFF, hold in HALT/IDLE, clear to 0 on Start.

Verification
REQ-033 SHALL verify: Reset, Start pulse, InstIn=9'h000 for 5 cycles -> InstAddress 0,1,2,3,4,5; InstValid=1; Done=0.
REQ-034 SHALL verify: PC=10, BranchAbs=1, BranchRel=1, Target=12'h020 -> next PC=0x020; then BranchRel=1, Target=12'hFFE -> PC=0x01E.
REQ-035 SHALL verify: PC=7, Stall=1 and BranchAbs=1 for 3 cycles -> PC stays 7; Stall released, no branch -> PC=8.
REQ-036 SHALL verify: PC=12'hFFF, no branch -> PC=0; InstIn=9'h1FF at PC=5 with Stall=1 -> HALT, Done=1, PC=5, InstValid=0.
REQ-037 SHALL verify: Reset asserted mid-clock during RUN at PC=40 -> PC=0, IDLE, Done=0 before next edge; Start in HALT -> PC=0, RUN, Done=0.
REQ-038 SHALL verify (FETCH_CYCLE_CNT_EN defined): Start, 6 RUN edges then halt -> CycleCnt=7 held in HALT; preloaded 16'hFFFF stays 16'hFFFF.

Source files
------------

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Program counter / instruction fetch sequencer for a simple core.
//            The PC drives the instruction ROM directly. The returned word
//            (InstIn) is consumed in the same cycle. An all-ones word halts
//            the program. Start (re)launches execution from address 0.
// Ports    : Clk          - sole clock, rising edge
//            Reset        - asynchronous, active-high reset
//            Start        - launch/restart request (highest priority after Reset)
//            Stall        - hold PC this cycle
//            BranchAbs    - PC <= Target
//            BranchRel    - PC <= PC + Target (two's complement, modulo 2^A)
//            Target [A]   - absolute address or relative offset
//            InstIn [W]   - instruction word for InstAddress (combinational ROM)
//            InstAddress  - current PC
//            InstValid    - high while in RUN
//            Done         - registered program-complete flag
//            CycleCnt[16] - saturating RUN-cycle counter (FETCH_CYCLE_CNT_EN only)
// Options  : define FETCH_CYCLE_CNT_EN to add the CycleCnt port and counter.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
  parameter int A = 12,
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Stall,
  input  logic         BranchAbs,
  input  logic         BranchRel,
  input  logic [A-1:0] Target,
  input  logic [W-1:0] InstIn,
  output logic [A-1:0] InstAddress,
  output logic         InstValid,
  output logic         Done
`ifdef FETCH_CYCLE_CNT_EN
  ,
  output logic [15:0]  CycleCnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [W-1:0] c_halt_word = {W{1'b1}};
  localparam logic [A-1:0] c_pc_one    = {{(A-1){1'b0}}, 1'b1};

  state_t       r_state;
  state_t       w_state_next;
  logic [A-1:0] r_pc;
  logic [A-1:0] w_pc_next;
  logic         r_done;
  logic         w_done_next;
  logic         w_halt;

  assign w_halt = (InstIn == c_halt_word);

  // State, PC and Done registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state logic. Start overrides everything; in RUN the halt word
  // outranks Stall and both branch kinds.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_done_next  = r_done;
    if (Start) begin
      w_state_next = ST_RUN;
      w_pc_next    = '0;
      w_done_next  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_pc_next   = '0;
          w_done_next = 1'b0;
        end
        ST_RUN: begin
          if (w_halt) begin
            w_state_next = ST_HALT;
            w_done_next  = 1'b1;
          end else if (Stall) begin
            w_pc_next = r_pc;
          end else if (BranchAbs) begin
            w_pc_next = Target;
          end else if (BranchRel) begin
            // Target already spans A bits, so sign extension to A bits is
            // the identity and a plain A-bit add wraps modulo 2^A.
            w_pc_next = r_pc + Target;
          end else begin
            w_pc_next = r_pc + c_pc_one;
          end
        end
        ST_HALT: begin
          w_done_next = 1'b1;
        end
        default: begin
          w_state_next = ST_IDLE;
          w_pc_next    = '0;
          w_done_next  = 1'b0;
        end
      endcase
    end
  end

  assign InstAddress = r_pc;
  assign InstValid   = (r_state == ST_RUN);
  assign Done        = r_done;

`ifdef FETCH_CYCLE_CNT_EN
  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  logic [15:0] r_cycle_cnt;

  // Counts every edge spent in RUN, including stalled and halting edges.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cycle_cnt <= '0;
    end else if (Start) begin
      r_cycle_cnt <= '0;
    end else if ((r_state == ST_RUN) && (r_cycle_cnt != c_cnt_max)) begin
      r_cycle_cnt <= r_cycle_cnt + 16'd1;
    end
  end

  assign CycleCnt = r_cycle_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Self-checking bench for inst_fetch: directed vector table,
//            reset/counter sequences and randomized run against a reference
//            model. Define FETCH_CYCLE_CNT_EN to also cover CycleCnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Stall;
  logic        BranchAbs;
  logic        BranchRel;
  logic [11:0] Target;
  logic [8:0]  InstIn;
  logic [11:0] InstAddress;
  logic        InstValid;
  logic        Done;
`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0] CycleCnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: state 0=idle 1=run 2=halt
  int m_state, m_pc, m_done, m_cnt;

  inst_fetch #(.A(12), .W(9)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Stall       (Stall),
    .BranchAbs   (BranchAbs),
    .BranchRel   (BranchRel),
    .Target      (Target),
    .InstIn      (InstIn),
    .InstAddress (InstAddress),
    .InstValid   (InstValid),
    .Done        (Done)
`ifdef FETCH_CYCLE_CNT_EN
    ,
    .CycleCnt    (CycleCnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit          start;
    bit          stall;
    bit          babs;
    bit          brel;
    logic [11:0] target;
    logic [8:0]  inst;
    logic [11:0] pc;
    bit          valid;
    bit          done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_pc = 0; m_done = 0; m_cnt = 0;
  endtask

  // One clock edge of the reference model using the inputs seen at the edge.
  task automatic m_step();
    int off;
    if (Start) begin
      m_state = 1; m_pc = 0; m_done = 0; m_cnt = 0;
    end else if (m_state == 0) begin
      m_pc = 0; m_done = 0;
    end else if (m_state == 1) begin
      if (m_cnt < 65535) m_cnt++;
      if (InstIn == 9'h1FF) begin
        m_state = 2; m_done = 1;
      end else if (Stall) begin
        // hold
      end else if (BranchAbs) begin
        m_pc = Target;
      end else if (BranchRel) begin
        off  = (Target >= 12'd2048) ? int'(Target) - 4096 : int'(Target);
        m_pc = (m_pc + off + 4096) % 4096;
      end else begin
        m_pc = (m_pc + 1) % 4096;
      end
    end else begin
      m_done = 1;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    if (!Reset) m_step();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},    int'(InstAddress), m_pc);
    chk({tag, ".valid"}, int'(InstValid),   (m_state == 1) ? 1 : 0);
    chk({tag, ".done"},  int'(Done),        m_done);
`ifdef FETCH_CYCLE_CNT_EN
    chk({tag, ".cnt"},   int'(CycleCnt),    m_cnt);
`endif
  endtask

  task automatic set_in(input bit st, input bit sl, input bit ba, input bit br,
                        input logic [11:0] t, input logic [8:0] ins);
    Start = st; Stall = sl; BranchAbs = ba; BranchRel = br; Target = t; InstIn = ins;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 12'h0, 9'h0);
    Reset = 1'b1;
    m_reset();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk("rst.pc", int'(InstAddress), 0);
    chk("rst.valid", int'(InstValid), 0);
    chk("rst.done", int'(Done), 0);
`ifdef FETCH_CYCLE_CNT_EN
    chk("rst.cnt", int'(CycleCnt), 0);
`endif
    tick();
    chk("idle.pc", int'(InstAddress), 0);
    chk("idle.valid", int'(InstValid), 0);

    // start stall babs brel target inst   -> pc valid done
    vecs.push_back('{1, 0, 0, 0, 12'h000, 9'h000, 12'h000, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 9'h000, 12'h001, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 9'h000, 12'h002, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 9'h000, 12'h003, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 9'h000, 12'h004, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 9'h000, 12'h005, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 12'h00A, 9'h000, 12'h00A, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 12'h020, 9'h000, 12'h020, 1, 0});
    vecs.push_back('{0, 0, 0, 1, 12'hFFE, 9'h000, 12'h01E, 1, 0});
    vecs.push_back('{0, 0, 0, 1, 12'h005, 9'h000, 12'h023, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 12'h007, 9'h000, 12'h007, 1, 0});
    vecs.push_back('{0, 1, 1, 0, 12'h100, 9'h000, 12'h007, 1, 0});
    vecs.push_back('{0, 1, 1, 0, 12'h100, 9'h000, 12'h007, 1, 0});
    vecs.push_back('{0, 1, 1, 0, 12'h100, 9'h000, 12'h007, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 12'h100, 9'h000, 12'h008, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 12'hFFF, 9'h000, 12'hFFF, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 9'h000, 12'h000, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 12'h005, 9'h000, 12'h005, 1, 0});
    vecs.push_back('{0, 1, 0, 0, 12'h000, 9'h1FF, 12'h005, 0, 1});
    vecs.push_back('{0, 1, 1, 1, 12'h009, 9'h000, 12'h005, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 9'h000, 12'h005, 0, 1});
    vecs.push_back('{1, 0, 0, 0, 12'h000, 9'h000, 12'h000, 1, 0});

    foreach (vecs[i]) begin
      set_in(vecs[i].start, vecs[i].stall, vecs[i].babs, vecs[i].brel,
             vecs[i].target, vecs[i].inst);
      tick();
      chk($sformatf("vec%0d.pc", i), int'(InstAddress), int'(vecs[i].pc));
      chk($sformatf("vec%0d.valid", i), int'(InstValid), int'(vecs[i].valid));
      chk($sformatf("vec%0d.done", i), int'(Done), int'(vecs[i].done));
`ifdef FETCH_CYCLE_CNT_EN
      chk($sformatf("vec%0d.cnt", i), int'(CycleCnt), m_cnt);
`endif
    end

    // Asynchronous reset in the middle of a RUN cycle at PC=40
    set_in(0, 0, 1, 0, 12'd40, 9'h000);
    tick();
    chk("pre_arst.pc", int'(InstAddress), 40);
    set_in(0, 0, 0, 0, 12'h000, 9'h000);
    #3;
    Reset = 1'b1;
    #1;
    m_reset();
    chk("arst.pc", int'(InstAddress), 0);
    chk("arst.valid", int'(InstValid), 0);
    chk("arst.done", int'(Done), 0);
    Start = 1'b1;
    tick();
    chk("start_in_rst.valid", int'(InstValid), 0);
    Reset = 1'b0;
    Start = 1'b0;
    tick();
    chk("post_rst.valid", int'(InstValid), 0);
    chk("post_rst.pc", int'(InstAddress), 0);

`ifdef FETCH_CYCLE_CNT_EN
    set_in(1, 0, 0, 0, 12'h000, 9'h000);
    tick();
    chk("cnt.start", int'(CycleCnt), 0);
    Start = 1'b0;
    repeat (6) tick();
    InstIn = 9'h1FF;
    tick();
    chk("cnt.halt", int'(CycleCnt), 7);
    chk("cnt.halt_done", int'(Done), 1);
    InstIn = 9'h000;
    repeat (2) tick();
    chk("cnt.hold", int'(CycleCnt), 7);
    set_in(1, 0, 0, 0, 12'h000, 9'h000);
    tick();
    set_in(0, 1, 0, 0, 12'h000, 9'h000);
    repeat (65540) tick();
    chk("cnt.sat", int'(CycleCnt), 16'hFFFF);
    InstIn = 9'h1FF;
    tick();
    chk("cnt.sat_halt", int'(CycleCnt), 16'hFFFF);
    chk("cnt.sat_done", int'(Done), 1);
`endif

    // Randomized run against the reference model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        Reset = 1'b1;
        #1;
        m_reset();
        chk_model("rnd_rst");
        Reset = 1'b0;
      end
      Start     = ($urandom_range(0, 39) == 0);
      Stall     = ($urandom_range(0, 3) == 0);
      BranchAbs = ($urandom_range(0, 7) == 0);
      BranchRel = ($urandom_range(0, 7) == 0);
      Target    = 12'($urandom);
      InstIn    = ($urandom_range(0, 19) == 0) ? 9'h1FF : 9'($urandom);
      tick();
      chk_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
